// File: rtl/register_file_sb_pkg.sv
// Shared constants and default-configuration types for the scoreboarded register file.
package regfile_pkg;

    localparam int REGFILE_DATA_WIDTH = 32;
    localparam int REGFILE_NUM_REGS   = 32;
    localparam int REGFILE_NUM_READ   = 2;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] reg_data_t;

endpackage

// File: rtl/register_file_sb_if.sv
// Decode/writeback-facing bus of the register file: read ports, writeback and issue.
interface register_file_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
    parameter int NUM_REGS   = REGFILE_NUM_REGS,
    parameter int NUM_READ   = REGFILE_NUM_READ
) ();
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NUM_READ-1:0][ADDR_W-1:0]     r_sel;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0] r_data;
    logic [NUM_READ-1:0]                 r_busy;
    logic                                w_en;
    logic [ADDR_W-1:0]                   w_sel;
    logic [DATA_WIDTH-1:0]               w_data;
    logic                                issue_en;
    logic [ADDR_W-1:0]                   issue_sel;
    logic [ADDR_W-1:0]                   busy_count;
    logic                                any_busy;

    modport master (
        output r_sel, w_en, w_sel, w_data, issue_en, issue_sel,
        input  r_data, r_busy, busy_count, any_busy
    );

    modport slave (
        input  r_sel, w_en, w_sel, w_data, issue_en, issue_sel,
        output r_data, r_busy, busy_count, any_busy
    );
endinterface

// File: rtl/register_file_sb_scoreboard.sv
// Busy-bit scoreboard: per-register pending-write flags and an incremental busy count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = REGFILE_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                issue_en_i,
    input  logic [ADDR_W-1:0]   issue_sel_i,
    input  logic                w_en_i,
    input  logic [ADDR_W-1:0]   w_sel_i,
    output logic [NUM_REGS-1:0] busy_o,
    output logic [ADDR_W-1:0]   busy_count_o
);
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] set_vec, clr_vec;
    logic [ADDR_W-1:0]   busy_count_q, busy_count_d;
    logic                inc, dec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int k = 1; k < NUM_REGS; k++) begin
            set_vec[k] = issue_en_i && (issue_sel_i == ADDR_W'(k));
            clr_vec[k] = w_en_i && (w_sel_i == ADDR_W'(k));
        end
        // Issue beats writeback: the write retires an older producer of the same register.
        busy_d    = (busy_q | set_vec) & ~(clr_vec & ~set_vec);
        busy_d[0] = 1'b0;

        inc = (issue_sel_i != '0) && issue_en_i && !busy_q[issue_sel_i];
        dec = (w_sel_i != '0) && w_en_i && busy_q[w_sel_i] &&
              !(issue_en_i && (issue_sel_i == w_sel_i));
        busy_count_d = busy_count_q + ADDR_W'(inc) - ADDR_W'(dec);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_o       = busy_q;
    assign busy_count_o = busy_count_q;
endmodule

// File: rtl/register_file_sb.sv
// Multi-read-port register file with busy-bit scoreboard; r0 reads zero and is never busy.
// Optional same-cycle write-to-read bypass is compiled in with REGFILE_BYPASS_EN.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
    parameter int NUM_REGS   = REGFILE_NUM_REGS,
    parameter int NUM_READ   = REGFILE_NUM_READ
) (
    input logic               clock,
    input logic               reset,
    register_file_sb_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]                 busy;
    logic [ADDR_W-1:0]                   busy_count;

    always_comb begin
        regs_d = regs_q;
        if (bus.w_en) begin
            regs_d[bus.w_sel] = bus.w_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clock        (clock),
        .reset        (reset),
        .issue_en_i   (bus.issue_en),
        .issue_sel_i  (bus.issue_sel),
        .w_en_i       (bus.w_en),
        .w_sel_i      (bus.w_sel),
        .busy_o       (busy),
        .busy_count_o (busy_count)
    );

    always_comb begin
        bus.r_data = '0;
        bus.r_busy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            bus.r_data[i] = regs_q[bus.r_sel[i]];
            bus.r_busy[i] = busy[bus.r_sel[i]];
`ifdef REGFILE_BYPASS_EN
            if (bus.w_en && (bus.w_sel != '0) && (bus.r_sel[i] == bus.w_sel)) begin
                bus.r_data[i] = bus.w_data;
                // A same-cycle issue to this register keeps it pending.
                if (!(bus.issue_en && (bus.issue_sel == bus.w_sel))) begin
                    bus.r_busy[i] = 1'b0;
                end
            end
`endif
        end
    end

    assign bus.busy_count = busy_count;
    assign bus.any_busy   = (busy_count != '0);
endmodule

// File: tb/tb_register_file_sb.sv
// Directed self-checking bench for register_file_sb (default 32x32, two read ports).
module tb_register_file_sb;
    import regfile_pkg::*;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [4:0]  sel0;
        logic [4:0]  sel1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } rd_vec_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    register_file_sb_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ(NRD)) bus ();

    register_file_sb #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ(NRD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    rd_vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.w_en      = 1'b0;
        bus.w_sel     = '0;
        bus.w_data    = '0;
        bus.issue_en  = 1'b0;
        bus.issue_sel = '0;
    endtask

    task automatic sel(input logic [4:0] s0, input logic [4:0] s1);
        bus.r_sel[0] = s0;
        bus.r_sel[1] = s1;
        #1;
    endtask

    initial begin
        vecs[0] = '{sel0: 5'd0,  sel1: 5'd0,  exp0: 32'd0,   exp1: 32'd0};
        vecs[1] = '{sel0: 5'd1,  sel1: 5'd1,  exp0: 32'd30,  exp1: 32'd30};
        vecs[2] = '{sel0: 5'd31, sel1: 5'd31, exp0: 32'd480, exp1: 32'd480};
        vecs[3] = '{sel0: 5'd5,  sel1: 5'd9,  exp0: 32'd90,  exp1: 32'd150};
        vecs[4] = '{sel0: 5'd16, sel1: 5'd0,  exp0: 32'd255, exp1: 32'd0};
        vecs[5] = '{sel0: 5'd7,  sel1: 5'd31, exp0: 32'd120, exp1: 32'd480};

        // Reset with a writeback and an issue held active.
        reset         = 1'b1;
        bus.r_sel     = '0;
        bus.w_en      = 1'b1;
        bus.w_sel     = 5'd5;
        bus.w_data    = 32'hDEAD;
        bus.issue_en  = 1'b1;
        bus.issue_sel = 5'd6;
        repeat (3) step();
        reset = 1'b0;
        idle();
        sel(5'd5, 5'd6);
        check("reset_r5_data", bus.r_data[0], 32'd0);
        check("reset_r6_busy", {31'd0, bus.r_busy[1]}, 32'd0);
        check("reset_busy_count", {27'd0, bus.busy_count}, 32'd0);
        check("reset_any_busy", {31'd0, bus.any_busy}, 32'd0);

        // Fill every register with (k+1)*15.
        for (int k = 0; k < NR; k++) begin
            bus.w_en   = 1'b1;
            bus.w_sel  = 5'(k);
            bus.w_data = 32'((k + 1) * 15);
            step();
        end
        idle();
        for (int k = 0; k < NR; k++) begin
            sel(5'(k), 5'(k));
            check("fill_port0", bus.r_data[0], (k == 0) ? 32'd0 : 32'((k + 1) * 15));
            check("fill_port1", bus.r_data[1], (k == 0) ? 32'd0 : 32'((k + 1) * 15));
        end
        for (int v = 0; v < 6; v++) begin
            sel(vecs[v].sel0, vecs[v].sel1);
            check("vec_port0", bus.r_data[0], vecs[v].exp0);
            check("vec_port1", bus.r_data[1], vecs[v].exp1);
        end

        // Issue r3 twice (WAW), then write it back.
        sel(5'd3, 5'd3);
        bus.issue_en = 1'b1; bus.issue_sel = 5'd3;
        step();
        check("r3_issue1_count", {27'd0, bus.busy_count}, 32'd1);
        check("r3_issue1_busy", {31'd0, bus.r_busy[0]}, 32'd1);
        step();
        check("r3_waw_count", {27'd0, bus.busy_count}, 32'd1);
        check("r3_waw_busy", {31'd0, bus.r_busy[1]}, 32'd1);
        idle();
        bus.w_en = 1'b1; bus.w_sel = 5'd3; bus.w_data = 32'd7;
        #1;
        check("r3_wb_same_busy", {31'd0, bus.r_busy[0]}, BYP ? 32'd0 : 32'd1);
        check("r3_wb_same_data", bus.r_data[0], BYP ? 32'd7 : 32'd60);
        step();
        idle();
        #1;
        check("r3_wb_count", {27'd0, bus.busy_count}, 32'd0);
        check("r3_wb_busy", {31'd0, bus.r_busy[0]}, 32'd0);
        check("r3_wb_data", bus.r_data[1], 32'd7);
        check("r3_wb_any_busy", {31'd0, bus.any_busy}, 32'd0);

        // Issue and writeback of busy r4 in the same cycle.
        sel(5'd4, 5'd4);
        bus.issue_en = 1'b1; bus.issue_sel = 5'd4;
        step();
        bus.w_en = 1'b1; bus.w_sel = 5'd4; bus.w_data = 32'hABCD;
        #1;
        check("r4_setclr_same_busy", {31'd0, bus.r_busy[0]}, 32'd1);
        check("r4_setclr_same_data", bus.r_data[0], BYP ? 32'hABCD : 32'd75);
        step();
        idle();
        #1;
        check("r4_setclr_busy", {31'd0, bus.r_busy[0]}, 32'd1);
        check("r4_setclr_count", {27'd0, bus.busy_count}, 32'd1);
        check("r4_setclr_data", bus.r_data[1], 32'hABCD);
        bus.w_en = 1'b1; bus.w_sel = 5'd4; bus.w_data = 32'hABCE;
        step();
        idle();
        #1;
        check("r4_clear_count", {27'd0, bus.busy_count}, 32'd0);

        // Same-cycle bypass of a fresh writeback to r9; port 1 watches r8.
        sel(5'd9, 5'd8);
        bus.w_en = 1'b1; bus.w_sel = 5'd9; bus.w_data = 32'h1234;
        #1;
        check("byp_same_data", bus.r_data[0], BYP ? 32'h1234 : 32'd150);
        check("byp_other_port", bus.r_data[1], 32'd135);
        step();
        idle();
        #1;
        check("byp_next_data", bus.r_data[0], 32'h1234);

        // Issue and write to r0 are both discarded.
        sel(5'd0, 5'd0);
        bus.issue_en = 1'b1; bus.issue_sel = 5'd0;
        bus.w_en = 1'b1; bus.w_sel = 5'd0; bus.w_data = 32'd5;
        #1;
        check("r0_same_data", bus.r_data[0], 32'd0);
        check("r0_same_busy", {31'd0, bus.r_busy[1]}, 32'd0);
        step();
        idle();
        #1;
        check("r0_data", bus.r_data[1], 32'd0);
        check("r0_busy", {31'd0, bus.r_busy[0]}, 32'd0);
        check("r0_count", {27'd0, bus.busy_count}, 32'd0);

        // Set+clear on a non-busy register counts as a new producer.
        sel(5'd10, 5'd11);
        bus.issue_en = 1'b1; bus.issue_sel = 5'd10;
        bus.w_en = 1'b1; bus.w_sel = 5'd10; bus.w_data = 32'd99;
        step();
        idle();
        bus.w_en = 1'b1; bus.w_sel = 5'd11; bus.w_data = 32'd11;
        step();
        idle();
        #1;
        check("r10_setclr_count", {27'd0, bus.busy_count}, 32'd1);
        check("r10_busy", {31'd0, bus.r_busy[0]}, 32'd1);
        check("r11_nonbusy_wb", {31'd0, bus.r_busy[1]}, 32'd0);
        bus.issue_en = 1'b1; bus.issue_sel = 5'd6;
        bus.w_en = 1'b1; bus.w_sel = 5'd10; bus.w_data = 32'd100;
        step();
        idle();
        sel(5'd6, 5'd10);
        check("swap_count", {27'd0, bus.busy_count}, 32'd1);
        check("swap_r6_busy", {31'd0, bus.r_busy[0]}, 32'd1);
        check("swap_r10_busy", {31'd0, bus.r_busy[1]}, 32'd0);

        // Issue every register: count saturates at NUM_REGS-1.
        for (int k = 0; k < NR; k++) begin
            bus.issue_en = 1'b1; bus.issue_sel = 5'(k);
            step();
        end
        idle();
        #1;
        check("full_count", {27'd0, bus.busy_count}, 32'd31);
        check("full_any_busy", {31'd0, bus.any_busy}, 32'd1);
        bus.issue_en = 1'b1; bus.issue_sel = 5'd5;
        step();
        idle();
        sel(5'd31, 5'd0);
        check("full_waw_count", {27'd0, bus.busy_count}, 32'd31);
        check("full_r31_busy", {31'd0, bus.r_busy[0]}, 32'd1);
        check("full_r0_busy", {31'd0, bus.r_busy[1]}, 32'd0);

        // Mid-operation reset with concurrent writeback and issue.
        reset = 1'b1;
        bus.w_en = 1'b1; bus.w_sel = 5'd5; bus.w_data = 32'hDEAD;
        bus.issue_en = 1'b1; bus.issue_sel = 5'd7;
        repeat (2) step();
        reset = 1'b0;
        idle();
        sel(5'd5, 5'd7);
        check("rst2_r5_data", bus.r_data[0], 32'd0);
        check("rst2_r7_busy", {31'd0, bus.r_busy[1]}, 32'd0);
        check("rst2_count", {27'd0, bus.busy_count}, 32'd0);
        check("rst2_any_busy", {31'd0, bus.any_busy}, 32'd0);
        sel(5'd9, 5'd31);
        check("rst2_r9_data", bus.r_data[0], 32'd0);
        check("rst2_r31_data", bus.r_data[1], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
